// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers.
// The S-box is derived from the field inverse and affine map rather than a table.
package aes_pkg;

  localparam int BW = 128;
  localparam int NK128 = 4;
  localparam int NK192 = 6;
  localparam int NK256 = 8;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } fsm_t;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, and maps 0 to 0
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] b;
    sq = a;
    b  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      b  = gmul(b, sq);
    end
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_encrypt_iterative_if.sv
// Block-in / ciphertext-out valid/ready bundle for the iterative AES core.
// master is the stream side, slave is the core.
interface aes_encrypt_iterative_if
  import aes_pkg::*;
#(
  parameter int KW = 128
) ();

  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in;
  logic [KW-1:0] key;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out;

  modport master (
    output in_valid, in, key, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in, key, out_ready,
    output in_ready, out_valid, out
  );

endinterface

// File: rtl/aes_encrypt_iterative_round_key_sel.sv
// Selects round key r from the flat schedule; round 0 is the top slice.
module aes_round_key_sel #(
  parameter int NR = 10,
  parameter int CW = $clog2(NR + 1)
) (
  input  logic [128*(NR+1)-1:0] sched,
  input  logic [CW-1:0]         idx,
  output logic [127:0]          rk
);
  always_comb begin
    rk = '0;
    for (int r = 0; r <= NR; r++)
      if (idx == CW'(r))
        rk = sched[128*(NR-r) +: 128];
  end
endmodule

// File: rtl/aes_primitives.sv
// AES round building blocks and the combinational key expansion.
// Byte 0 of every 128-bit block sits in bits [127:120], column-major.
module subBytes
  import aes_pkg::*;
(
  input  logic [127:0] in,
  output logic [127:0] out
);
  always_comb begin
    out = '0;
    for (int i = 0; i < 16; i++)
      out[8*i +: 8] = sbox(in[8*i +: 8]);
  end
endmodule

module shiftRows (
  input  logic [127:0] in,
  output logic [127:0] out
);
  // row r of column c takes the byte from column (c+r) mod 4
  always_comb begin
    out = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        out[127-8*(r+4*c) -: 8] = in[127-8*(r+4*((c+r)%4)) -: 8];
  end
endmodule

module addRoundKey (
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic [127:0] out
);
  assign out = in ^ key;
endmodule

module encryptRound
  import aes_pkg::*;
(
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic [127:0] out
);
  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;

  subBytes    u_sb (.in(in), .out(sb));
  shiftRows   u_sr (.in(sb), .out(sr));

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++)
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
  end

  addRoundKey u_ark (.in(mc), .key(key), .out(out));
endmodule

module keyExpansion
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic [32*NK-1:0]      key,
  output logic [128*(NR+1)-1:0] w
);
  localparam int NW = 4 * (NR + 1);

  logic [31:0] wd [NW];
  logic [31:0] t;
  logic [7:0]  rc;

  always_comb begin
    w  = '0;
    t  = '0;
    rc = 8'h01;
    for (int i = 0; i < NW; i++) begin
      if (i < NK) begin
        wd[i] = key[32*(NK-i)-1 -: 32];
      end else begin
        t = wd[i-1];
        if (i % NK == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xtime(rc);
        end else if (NK > 6 && i % NK == 4) begin
          t = sub_word(t);
        end
        wd[i] = wd[i-NK] ^ t;
      end
      w[128*(NR+1)-1-32*i -: 32] = wd[i];
    end
  end
endmodule

// File: rtl/aes_encrypt_iterative.sv
// Iterative AES encryptor: one round per clock, AES-128/192/256 by NK.
// Ciphertext is the state register itself, held under backpressure.
module aes_encrypt_iterative
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  aes_encrypt_iterative_if.slave  bus,
  output logic                    busy
);
  localparam int NR = nr_of(NK);
  localparam int KW = 32 * NK;
  localparam int CW = $clog2(NR + 1);
  localparam int SW = 128 * (NR + 1);

  generate
    if (NK != NK128 && NK != NK192 && NK != NK256) begin : g_bad_nk
      $error("aes_encrypt_iterative: NK must be 4, 6 or 8");
    end
  endgenerate

  fsm_t          st;
  logic [CW-1:0] cnt;
  logic [BW-1:0] state_q;
  logic [KW-1:0] key_q;
  logic          ov_q;

  logic [SW-1:0] sched;
  logic [BW-1:0] rk;
  logic [BW-1:0] init_st;
  logic [BW-1:0] rnd_out;
  logic [BW-1:0] fin_sb;
  logic [BW-1:0] fin_sr;
  logic [BW-1:0] fin_out;
  logic          accept;

  keyExpansion #(.NK(NK), .NR(NR)) u_kexp (
    .key(key_q), .w(sched)
  );

  aes_round_key_sel #(.NR(NR), .CW(CW)) u_sel (
    .sched(sched), .idx(cnt), .rk(rk)
  );

  // round key 0 is the raw key head, so the new key needs no expansion
  addRoundKey u_ark0 (
    .in(bus.in), .key(bus.key[KW-1 -: 128]), .out(init_st)
  );

  encryptRound u_rnd (
    .in(state_q), .key(rk), .out(rnd_out)
  );

  subBytes    u_fsb (.in(state_q), .out(fin_sb));
  shiftRows   u_fsr (.in(fin_sb), .out(fin_sr));
  addRoundKey u_fark (.in(fin_sr), .key(rk), .out(fin_out));

  assign bus.in_ready = !rst &&
    (st == IDLE || (st == DONE && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out       = state_q;
  assign bus.out_valid = ov_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      state_q <= '0;
      key_q   <= '0;
      ov_q    <= 1'b0;
      busy    <= 1'b0;
    end else if (accept) begin
      key_q   <= bus.key;
      state_q <= init_st;
      cnt     <= CW'(1);
      st      <= ROUND;
      ov_q    <= 1'b0;
      busy    <= 1'b1;
    end else begin
      unique case (st)
        IDLE: ;
        ROUND: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(NR)) begin
            state_q <= fin_out;
            st      <= DONE;
            ov_q    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state_q <= rnd_out;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            st   <= IDLE;
            ov_q <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iterative.sv
// Directed FIPS-197 vectors against AES-128/192/256 instances of the core.
module tb_aes_encrypt_iterative;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K4  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K6  =
    192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K8  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C4  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C6  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C8  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst;
  logic busy4, busy6, busy8;

  int n_checks = 0;
  int n_errors = 0;

  aes_encrypt_iterative_if #(.KW(128)) b4 ();
  aes_encrypt_iterative_if #(.KW(192)) b6 ();
  aes_encrypt_iterative_if #(.KW(256)) b8 ();

  aes_encrypt_iterative #(.NK(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(b4.slave), .busy(busy4)
  );
  aes_encrypt_iterative #(.NK(6)) u_dut6 (
    .clk(clk), .rst(rst), .bus(b6.slave), .busy(busy6)
  );
  aes_encrypt_iterative #(.NK(8)) u_dut8 (
    .clk(clk), .rst(rst), .bus(b8.slave), .busy(busy8)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] p);
    int n;
    n = 0;
    b4.key      = k;
    b4.in       = p;
    b4.in_valid = 1'b1;
    while (!b4.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", 128'(b4.in_ready), 128'd1);
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
  endtask

  task automatic wait_out(
    input string        tag,
    input logic [127:0] exp,
    input bit           jit
  );
    int lat;
    lat = 1;
    while (!b4.out_valid && lat < 40) begin
      if (jit) begin
        b4.in_valid = (lat < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
        b4.in = {$urandom, $urandom, $urandom, $urandom};
        b4.key = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
      lat++;
    end
    b4.in_valid = 1'b0;
    chk({tag, "_lat"}, 128'(lat), 128'd11);
    chk(tag, b4.out, exp);
  endtask

  initial begin
    int l4, l6, l8;
    logic [127:0] o4, o6, o8;

    rst = 1'b1;
    b4.in_valid = 1'b0; b4.in = '0; b4.key = '0; b4.out_ready = 1'b1;
    b6.in_valid = 1'b0; b6.in = '0; b6.key = '0; b6.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.in = '0; b8.key = '0; b8.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(b4.out_valid), 128'd0);
    chk("rst_out", b4.out, 128'd0);
    chk("rst_busy", 128'(busy4), 128'd0);
    chk("rst_in_ready", 128'(b4.in_ready), 128'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 128'(b4.in_ready), 128'd1);

    // same plaintext into all three key sizes at once
    b4.key = K4; b6.key = K6; b8.key = K8;
    b4.in = PT;  b6.in = PT;  b8.in = PT;
    b4.in_valid = 1'b1; b6.in_valid = 1'b1; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b4.in_valid = 1'b0; b6.in_valid = 1'b0; b8.in_valid = 1'b0;
    chk("busy_round", 128'(busy4), 128'd1);
    l4 = 0; l6 = 0; l8 = 0;
    o4 = '0; o6 = '0; o8 = '0;
    for (int n = 1; n <= 40; n++) begin
      if (b4.out_valid && l4 == 0) begin l4 = n; o4 = b4.out; end
      if (b6.out_valid && l6 == 0) begin l6 = n; o6 = b6.out; end
      if (b8.out_valid && l8 == 0) begin l8 = n; o8 = b8.out; end
      if (l4 != 0 && l6 != 0 && l8 != 0) break;
      @(posedge clk); #1;
    end
    chk("aes128_lat", 128'(l4), 128'd11);
    chk("aes192_lat", 128'(l6), 128'd13);
    chk("aes256_lat", 128'(l8), 128'd15);
    chk("aes128_out", o4, C4);
    chk("aes192_out", o6, C6);
    chk("aes256_out", o8, C8);
    chk("idle_out_valid", 128'(b4.out_valid), 128'd0);
    chk("idle_out_kept", b4.out, C4);
    chk("idle_busy", 128'(busy4), 128'd0);

    // backpressure with a pending input that must wait
    b4.out_ready = 1'b0;
    send(KB, PB);
    wait_out("bp", CB, 1'b0);
    b4.key = K4;
    b4.in = PT;
    b4.in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_out", b4.out, CB);
      chk("bp_hold_valid", 128'(b4.out_valid), 128'd1);
      chk("bp_in_ready", 128'(b4.in_ready), 128'd0);
    end
    b4.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 128'(b4.in_ready), 128'd1);
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    chk("bp_accept_valid", 128'(b4.out_valid), 128'd0);
    chk("bp_accept_busy", 128'(busy4), 128'd1);
    wait_out("after_bp", C4, 1'b0);

    // next block handed over in the very cycle the result is taken
    b4.key = KB;
    b4.in = PB;
    b4.in_valid = 1'b1;
    #1;
    chk("b2b_in_ready", 128'(b4.in_ready), 128'd1);
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    chk("b2b_valid_drop", 128'(b4.out_valid), 128'd0);
    chk("b2b_busy", 128'(busy4), 128'd1);
    wait_out("b2b", CB, 1'b0);

    // in_valid noise while rounds run
    send(K4, PT);
    wait_out("jitter", C4, 1'b1);
    @(posedge clk); #1;
    chk("jitter_idle_valid", 128'(b4.out_valid), 128'd0);
    chk("jitter_idle_busy", 128'(busy4), 128'd0);

    // reset at round 5
    send(KB, PB);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 128'(b4.out_valid), 128'd0);
    chk("mid_rst_out", b4.out, 128'd0);
    chk("mid_rst_busy", 128'(busy4), 128'd0);
    chk("mid_rst_ready", 128'(b4.in_ready), 128'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 128'(b4.in_ready), 128'd1);
    send(K4, PT);
    wait_out("post_rst", C4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_iterative.md
Name: aes_encrypt_iterative

Overview:
- Iterative AES encryption core: one AES round per clock, key size selected by parameter (AES-128/192/256).
- Parametrised, sequential successor to the fully unrolled combinational encryptor; trades latency for area.
- Valid/ready handshakes on input and output, with output hold under backpressure.
- Sits between a block-stream source (mode wrapper or DMA) and a ciphertext sink.

Parameters:
- NK, 4, key length in 32-bit words; legal values 4, 6, 8; any other value is an elaboration error.
- NR, NK+6, number of rounds; localparam, not overridable.
- KW, 32*NK, key width in bits; localparam.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  plaintext and key present.
- in_ready  output  1  core can accept a block this cycle.
- in  input  128  plaintext block, byte 0 in bits [127:120].
- key  input  KW  cipher key, sampled together with `in`.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  sink accepts ciphertext.
- out  output  128  ciphertext block.
- busy  output  1  high in ROUND state.

Behaviour:
- Reset (rst high at a clock edge):
  - FSM goes to IDLE; round counter = 0; state register = 0; key register = 0; out = 0; out_valid = 0; busy = 0.
  - in_ready is forced low while rst is high.
  - A reset during ROUND or DONE discards the block in flight; no partial output appears.
- Accept: occurs on the cycle where in_valid && in_ready (cycle T).
  - Key register <= key.
  - State register <= in XOR round key 0.
  - Round counter <= 1.
  - FSM -> ROUND.
- Key schedule:
  - Computed combinationally from the key register by the existing keyExpansion instance (NK, NR).
  - Round key r is the 128-bit slice at index r: round 0 = most-significant 128 bits, round NR = least-significant 128 bits.
- ROUND state, counter value r:
  - For 1 <= r < NR: state <= encryptRound(state, rk[r]).
  - For r = NR: state <= addRoundKey(shiftRows(subBytes(state)), rk[NR]); no MixColumns on the final round.
  - Counter increments each cycle. After the r = NR update, FSM -> DONE.
- Latency:
  - out_valid rises at cycle T+NR+1, i.e. 11, 13 or 15 cycles after accept for AES-128/192/256.
  - out is the state register driven directly; no extra output stage.
- DONE state:
  - out_valid = 1; out stays stable until out_ready.
  - If out_ready = 0: hold indefinitely; out and out_valid unchanged; in_ready = 0.
  - If out_ready = 1 and in_valid = 1: in_ready = 1. The output handshake and a new input accept complete in the same cycle, giving back-to-back operation with no bubble; FSM -> ROUND with the new block.
  - If out_ready = 1 and in_valid = 0: FSM -> IDLE; out_valid = 0 next cycle.
  - out retains its last value after leaving DONE until a new block overwrites the state register.
- in_ready = (state == IDLE) || (state == DONE && out_ready), gated low by rst. Combinational path from out_ready to in_ready is permitted.
- in_valid is ignored during ROUND: no accept, and the inputs are not sampled.
- Throughput: one block per NR+1 cycles when the sink never stalls.
- Counter width: clog2(NR+1) bits.
- The key register is reloaded on every accept; there is no cross-block key persistence requirement.

Decomposition:
- Shared package aes_pkg holds:
  - block width constant 128;
  - a function nr_of(nk) returning nk+6;
  - FSM state encoding IDLE/ROUND/DONE;
  - legal NK constants 4/6/8.
- Reuse existing modules: keyExpansion, encryptRound, subBytes, shiftRows, addRoundKey. No new per-round logic is written.
- One natural new sub-module, aes_round_key_sel: parametrised mux from the flat key schedule to rk[r], indexed by the round counter.

Test Plan:
- NK=4: key 000102030405060708090a0b0c0d0e0f, in 00112233445566778899aabbccddeeff -> out 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid exactly 11 cycles after accept.
- NK=6: key 000102…1617, same plaintext -> dda97ca4864cdfe06eaf70a0ec0d7191, 13 cycles. NK=8: key 000102…1e1f -> 8ea2b7ca516745bfeafc49904b496089, 15 cycles.
- Backpressure, NK=4: key 2b7e151628aed2a6abf7158809cf4f3c, in 3243f6a8885a308d313198a2e0370734; out_ready low for 20 cycles -> out holds 3925841d02dc09fbdc118597196a0b32 and in_ready = 0 throughout; in_valid held high is not accepted until out_ready rises.
- Back-to-back: two blocks, second presented while in DONE with out_ready = 1 -> second accepted in the same cycle as the first is consumed; second result 11 cycles later; both match the FIPS-197 vectors.
- Reset mid-round: assert rst at round 5 -> next cycle out_valid = 0, out = 0, busy = 0; in_ready = 1 in the first cycle after rst deasserts; a fresh block then produces the correct ciphertext.
- in_valid toggled randomly during ROUND -> no extra accepts; result unaffected.
